// File: rtl/imem_loader.sv
// Loads the instruction memory from the debug-unit byte stream, packing big-endian
// 32-bit words and writing one word per WRITE cycle until the halt word or DEPTH words.
module imem_loader #(
   parameter int          DEPTH     = 32,
   parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
   localparam int         CW        = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [7:0]    rx_data,
   input  logic          rx_valid,
   output logic          rx_ready,
   output logic          wr_instruction,
   output logic [31:0]   wr_addr,
   output logic [31:0]   data_instruction,
   output logic          load_busy,
   output logic          load_done,
   output logic          trunc_err,
   output logic [CW-1:0] word_count
);

   // state | meaning
   // IDLE  | waiting for the first start after reset
   // RECV  | accepting bytes of the current word
   // WRITE | one-cycle memory write of the assembled word
   // DONE  | session ended, waiting for a new start
   typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

   state_t        state_q, state_d;
   logic          rx_ready_q, rx_ready_d;
   logic          load_done_q, load_done_d;
   logic          trunc_err_q, trunc_err_d;
   logic [31:0]   data_q, data_d;
   logic [1:0]    byte_idx_q, byte_idx_d;
   logic [CW-1:0] word_count_q, word_count_d;
   logic [CW-1:0] word_count_inc;

   assign word_count_inc = word_count_q + CW'(1);

   always_comb begin
      state_d      = state_q;
      load_done_d  = load_done_q;
      trunc_err_d  = trunc_err_q;
      data_d       = data_q;
      byte_idx_d   = byte_idx_q;
      word_count_d = word_count_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d      = RECV;
               load_done_d  = 1'b0;
               trunc_err_d  = 1'b0;
               byte_idx_d   = 2'd0;
               word_count_d = '0;
            end
         end
         RECV: begin
            if (rx_valid && rx_ready_q) begin
               data_d     = {data_q[23:0], rx_data};
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) state_d = WRITE;
            end
         end
         WRITE: begin
            word_count_d = word_count_inc;
            if (data_q == HALT_WORD) begin
               state_d     = DONE;
               load_done_d = 1'b1;
            end else if (word_count_inc == CW'(DEPTH)) begin
               state_d     = DONE;
               load_done_d = 1'b1;
               trunc_err_d = 1'b1;
            end else begin
               state_d = RECV;
            end
         end
         default: state_d = IDLE;
      endcase
      // Registered ready follows the next state so it drops in the same edge as the 4th byte.
      rx_ready_d = (state_d == RECV);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         rx_ready_q   <= 1'b0;
         load_done_q  <= 1'b0;
         trunc_err_q  <= 1'b0;
         data_q       <= '0;
         byte_idx_q   <= '0;
         word_count_q <= '0;
      end else begin
         state_q      <= state_d;
         rx_ready_q   <= rx_ready_d;
         load_done_q  <= load_done_d;
         trunc_err_q  <= trunc_err_d;
         data_q       <= data_d;
         byte_idx_q   <= byte_idx_d;
         word_count_q <= word_count_d;
      end
   end

   assign rx_ready         = rx_ready_q;
   assign wr_instruction   = (state_q == WRITE);
   assign wr_addr          = {{(32 - CW){1'b0}}, word_count_q};
   assign data_instruction = data_q;
   assign load_busy        = (state_q == RECV) || (state_q == WRITE);
   assign load_done        = load_done_q;
   assign trunc_err        = trunc_err_q;
   assign word_count       = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: logs every memory write and checks addresses, data,
// status flags and handshake behaviour against hand-computed values.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic        wr_instruction;
   logic [31:0] wr_addr;
   logic [31:0] data_instruction;
   logic        load_busy;
   logic        load_done;
   logic        trunc_err;
   logic [5:0]  word_count;

   imem_loader #(.DEPTH(32), .HALT_WORD(32'hFFFF_FFFF)) dut (
      .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .wr_instruction(wr_instruction), .wr_addr(wr_addr),
      .data_instruction(data_instruction), .load_busy(load_busy), .load_done(load_done),
      .trunc_err(trunc_err), .word_count(word_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // write log, filled only by the monitor below
   int          nwr = 0;
   int          bad_ready = 0;
   int          cyc = 0;
   logic [31:0] log_addr [0:255];
   logic [31:0] log_data [0:255];
   int          log_cyc  [0:255];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (wr_instruction) begin
         if (nwr < 256) begin
            log_addr[nwr] = wr_addr;
            log_data[nwr] = data_instruction;
            log_cyc[nwr]  = cyc;
         end
         if (rx_ready) bad_ready = bad_ready + 1;
         nwr = nwr + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      rx_valid = 1'b0;
      repeat (gap) tick();
      rx_data  = b;
      rx_valid = 1'b1;
      t = 0;
      while (!rx_ready && t < 50) begin
         tick();
         t++;
      end
      if (t >= 50) chk("byte_accept_timeout", 32'd1, 32'd0);
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int maxgap);
      send_byte(w[31:24], (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
      send_byte(w[23:16], (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
      send_byte(w[15:8],  (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
      send_byte(w[7:0],   (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int bad_before;
      int ok;

      // ---- reset with random inputs
      repeat (4) begin
         start    = 1'($urandom);
         rx_valid = 1'($urandom);
         rx_data  = 8'($urandom);
         tick();
      end
      chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
      chk("rst_wr", {31'd0, wr_instruction}, 32'd0);
      chk("rst_busy", {31'd0, load_busy}, 32'd0);
      chk("rst_done", {31'd0, load_done}, 32'd0);
      chk("rst_trunc", {31'd0, trunc_err}, 32'd0);
      chk("rst_addr", wr_addr, 32'd0);
      chk("rst_data", data_instruction, 32'd0);
      chk("rst_wc", {26'd0, word_count}, 32'd0);
      start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      rst = 1'b1;
      repeat (10) tick();
      chk("idle_rx_ready", {31'd0, rx_ready}, 32'd0);
      chk("idle_busy", {31'd0, load_busy}, 32'd0);
      chk("idle_nwr", nwr, 32'd0);

      // ---- normal back-to-back load
      base = nwr; bad_before = bad_ready;
      pulse_start();
      chk("start_rx_ready", {31'd0, rx_ready}, 32'd1);
      chk("start_busy", {31'd0, load_busy}, 32'd1);
      send_word(32'h0022_1820, 0);
      send_word(32'h0022_2022, 0);
      send_word(32'hFFFF_FFFF, 0);
      tick();
      chk("norm_nwr", nwr - base, 32'd3);
      chk("norm_a0", log_addr[base], 32'd0);
      chk("norm_d0", log_data[base], 32'h0022_1820);
      chk("norm_a1", log_addr[base+1], 32'd1);
      chk("norm_d1", log_data[base+1], 32'h0022_2022);
      chk("norm_a2", log_addr[base+2], 32'd2);
      chk("norm_d2", log_data[base+2], 32'hFFFF_FFFF);
      chk("norm_gap01", log_cyc[base+1] - log_cyc[base], 32'd5);
      chk("norm_gap12", log_cyc[base+2] - log_cyc[base+1], 32'd5);
      chk("norm_wc", {26'd0, word_count}, 32'd3);
      chk("norm_done", {31'd0, load_done}, 32'd1);
      chk("norm_trunc", {31'd0, trunc_err}, 32'd0);
      chk("norm_busy", {31'd0, load_busy}, 32'd0);
      chk("norm_ready_in_write", bad_ready - bad_before, 32'd0);

      // ---- same stream with random gaps, started from DONE
      base = nwr; bad_before = bad_ready;
      pulse_start();
      chk("gap_done_clear", {31'd0, load_done}, 32'd0);
      send_word(32'h0022_1820, 3);
      send_word(32'h0022_2022, 3);
      send_word(32'hFFFF_FFFF, 3);
      tick();
      chk("gap_nwr", nwr - base, 32'd3);
      chk("gap_d0", log_data[base], 32'h0022_1820);
      chk("gap_d1", log_data[base+1], 32'h0022_2022);
      chk("gap_d2", log_data[base+2], 32'hFFFF_FFFF);
      chk("gap_a2", log_addr[base+2], 32'd2);
      chk("gap_wc", {26'd0, word_count}, 32'd3);
      chk("gap_ready_in_write", bad_ready - bad_before, 32'd0);

      // ---- truncation: 32 zero words, no halt
      base = nwr;
      pulse_start();
      for (int i = 0; i < 32; i++) send_word(32'h0000_0000, 0);
      tick();
      chk("trunc_nwr", nwr - base, 32'd32);
      ok = 1;
      for (int i = 0; i < 32; i++)
         if (log_addr[base+i] !== i || log_data[base+i] !== 32'd0) ok = 0;
      chk("trunc_addrs", ok, 32'd1);
      chk("trunc_a31", log_addr[base+31], 32'd31);
      chk("trunc_wc", {26'd0, word_count}, 32'd32);
      chk("trunc_err", {31'd0, trunc_err}, 32'd1);
      chk("trunc_done", {31'd0, load_done}, 32'd1);
      rx_data = 8'h5A; rx_valid = 1'b1;
      ok = 1;
      repeat (5) begin
         if (rx_ready !== 1'b0) ok = 0;
         tick();
      end
      rx_valid = 1'b0;
      chk("trunc_no_accept", ok, 32'd1);
      chk("trunc_no_extra_wr", nwr - base, 32'd32);

      // ---- halt at the last address is not a truncation
      base = nwr;
      pulse_start();
      chk("last_trunc_clear", {31'd0, trunc_err}, 32'd0);
      for (int i = 0; i < 31; i++) send_word(32'h1234_0000 + i, 0);
      send_word(32'hFFFF_FFFF, 0);
      tick();
      chk("last_nwr", nwr - base, 32'd32);
      chk("last_a31", log_addr[base+31], 32'd31);
      chk("last_d30", log_data[base+30], 32'h1234_001E);
      chk("last_wc", {26'd0, word_count}, 32'd32);
      chk("last_trunc", {31'd0, trunc_err}, 32'd0);
      chk("last_done", {31'd0, load_done}, 32'd1);

      // ---- reset in the middle of a word
      pulse_start();
      base = nwr;
      send_byte(8'hAA, 0);
      send_byte(8'hBB, 0);
      #2 rst = 1'b0;
      #1;
      chk("mid_async_busy", {31'd0, load_busy}, 32'd0);
      chk("mid_async_data", data_instruction, 32'd0);
      tick();
      rst = 1'b1;
      tick();
      chk("mid_rx_ready", {31'd0, rx_ready}, 32'd0);
      chk("mid_wc", {26'd0, word_count}, 32'd0);
      chk("mid_done", {31'd0, load_done}, 32'd0);
      chk("mid_no_wr", nwr - base, 32'd0);
      pulse_start();
      send_word(32'h0102_0304, 0);
      send_word(32'hFFFF_FFFF, 0);
      tick();
      chk("mid_nwr", nwr - base, 32'd2);
      chk("mid_a0", log_addr[base], 32'd0);
      chk("mid_d0", log_data[base], 32'h0102_0304);
      chk("mid_a1", log_addr[base+1], 32'd1);
      chk("mid_d1", log_data[base+1], 32'hFFFF_FFFF);

      // ---- start pulses during RECV are ignored
      base = nwr;
      pulse_start();
      send_word(32'hDEAD_BEEF, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      pulse_start();
      chk("recv_start_wc", {26'd0, word_count}, 32'd1);
      chk("recv_start_busy", {31'd0, load_busy}, 32'd1);
      send_byte(8'h33, 0);
      send_byte(8'h44, 0);
      send_word(32'hFFFF_FFFF, 0);
      tick();
      chk("recv_start_nwr", nwr - base, 32'd3);
      chk("recv_start_a1", log_addr[base+1], 32'd1);
      chk("recv_start_d1", log_data[base+1], 32'h1122_3344);
      chk("recv_start_final_wc", {26'd0, word_count}, 32'd3);

      // ---- start in DONE restarts at address 0
      base = nwr;
      pulse_start();
      chk("done_start_clear", {31'd0, load_done}, 32'd0);
      chk("done_start_wc", {26'd0, word_count}, 32'd0);
      send_word(32'hCAFE_F00D, 0);
      send_word(32'hFFFF_FFFF, 0);
      tick();
      chk("done_start_a0", log_addr[base], 32'd0);
      chk("done_start_d0", log_data[base], 32'hCAFE_F00D);
      chk("done_start_done", {31'd0, load_done}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Sequencer that fills the instruction memory from the debug unit before the processor runs. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. It drives the instruction memory write port (`wr_instruction`, `data_instruction`, address) for each word, then reports completion so the debug unit can release the pipeline. It sits between the debug-unit UART receiver and the instruction memory, and owns the memory address bus only while a load session is active.

## Interface
Parameters:
- `DEPTH`, 32: number of instruction memory words; also the maximum words per session.
- `HALT_WORD`, 32'hFFFF_FFFF: end-of-program marker. It is written to memory and then ends the session.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `start`  in  1  single-cycle request to begin a load session.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader can accept a byte this cycle.
- `wr_instruction`  out  1  instruction memory write enable.
- `wr_addr`  out  32  instruction memory word address. It is `word_count` zero-extended and connects to the memory's address input while `load_busy`=1.
- `data_instruction`  out  32  word to write.
- `load_busy`  out  1  session in progress (states RECV or WRITE).
- `load_done`  out  1  session ended; a level signal, held until the next `start` or reset.
- `trunc_err`  out  1  `DEPTH` words were written without a `HALT_WORD`.
- `word_count`  out  $clog2(DEPTH+1)  words written this session, including the halt word.

## Operation
- Reset (`rst`=0, at any time, in any state):
  - State goes to IDLE.
  - `rx_ready`, `wr_instruction`, `load_busy`, `load_done`, `trunc_err` = 0.
  - `wr_addr`, `data_instruction`, `word_count` = 0; the byte index = 0.
  - A partially assembled word is discarded.
- States:
  - IDLE: `rx_ready`=0. `start`=1 → RECV; clears `word_count`, the byte index, `load_done` and `trunc_err`.
  - RECV: `rx_ready`=1, `load_busy`=1.
    - Each accepted byte (`rx_valid & rx_ready` at a rising edge) shifts in MSB-first: `data_instruction <= {data_instruction[23:0], rx_data}`.
    - Byte index increments modulo 4. Acceptance of the 4th byte → WRITE.
  - WRITE: exactly one cycle.
    - `wr_instruction`=1, `rx_ready`=0, `wr_addr`=`word_count`, `data_instruction` stable.
    - Leaving WRITE, `word_count` increments.
    - Next state: if the word equals `HALT_WORD` → DONE. Else if the new `word_count` == `DEPTH` → DONE with `trunc_err`=1. Else → RECV.
  - DONE: `load_done`=1, `rx_ready`=0, `load_busy`=0. `start`=1 → RECV with the same clears as from IDLE.
- `start` is ignored in RECV and WRITE.
- Bytes presented while `rx_ready`=0 are not consumed. The sender holds them.
- A halt word arriving at address `DEPTH-1` ends the session with `trunc_err`=0.
- `wr_instruction` is never asserted outside WRITE. The loader never reads the memory.

## Timing
- `rx_ready` is registered, derived from the state.
- When the 4th byte is accepted at rising edge k:
  - `wr_instruction`=1 from edge k to edge k+1. The memory's negative-edge write samples stable address and data.
  - `word_count` updates at edge k+1.
  - `load_done` (on halt or truncation) rises at edge k+1.
- Peak throughput: 5 cycles per word (4 byte cycles + 1 write cycle). Gaps in `rx_valid` stretch RECV only.
- Session latency from `start`: `rx_ready` rises one cycle after the `start` edge.
- Asynchronous reset takes effect immediately on `rst` falling. It releases synchronously on the first rising edge after `rst`=1.

## Test plan
- Reset: hold `rst`=0 with random inputs → all outputs 0, `rx_ready`=0. Release and wait 10 cycles with no `start` → still IDLE, no writes.
- Normal load: `start`, then bytes 00 22 18 20, 00 22 20 22, FF FF FF FF back-to-back → exactly three writes: addr0=32'h00221820, addr1=32'h00222022, addr2=32'hFFFFFFFF. Expect `word_count`=3, `load_done`=1, `trunc_err`=0, and write pulses 5 cycles apart.
- Backpressure/gaps: same stream with `rx_valid` low for 0-3 random cycles between bytes → identical writes and data. No byte is lost or duplicated, and `rx_ready`=0 during each WRITE cycle.
- Truncation: 32 words of 32'h00000000 with no halt → 32 writes at addresses 0..31, `word_count`=32, `trunc_err`=1, `load_done`=1. A further byte offered stays unaccepted.
- Reset mid-word: after bytes AA BB, drive `rst`=0 for one cycle → IDLE, no write occurs. Then `start`, bytes 01 02 03 04 and a halt → addr0=32'h01020304, addr1=32'hFFFFFFFF.
- `start` handling: pulse `start` during RECV → no effect on count or address. Pulse `start` in DONE → `load_done` clears next cycle, and the next word is written at address 0.
